// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory slave.
package apb_pkg;

  // Transfer FSM: waiting for setup, counting wait states, one-cycle post-completion.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } apb_slv_state_t;

  localparam logic APB_RESP_OKAY = 1'b0;
  localparam logic APB_RESP_ERR  = 1'b1;

  // Wide enough for the largest wait-state setting (15).
  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter: loadable, decrements on request, saturates at zero.
module apb_wait_counter
  import apb_pkg::*;
(
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  logic                  load_i,
  input  logic [WAIT_CNT_W-1:0] load_val_i,
  input  logic                  dec_i,
  output logic [WAIT_CNT_W-1:0] count_o,
  output logic                  zero_o
);

  logic [WAIT_CNT_W-1:0] count_q, count_d;

  // Load has priority; decrement stops at zero rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WAIT_CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/apb_mem_slave.sv
// APB word-addressed memory slave with programmable wait states, a read-only
// upper region and decode-error reporting.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned RO_BASE     = DEPTH
) (
  input  logic                PCLK,
  input  logic                PRESET_n,
  input  logic                PSEL_i,
  input  logic                PENABLE_i,
  input  logic                PWRITE_i,
  input  logic [ADDR_W-1:0]   PADDR_i,
  input  logic [DATA_W-1:0]   PWDATA_i,
  input  logic [DATA_W/8-1:0] PSTRB_i,
  output logic [DATA_W-1:0]   PRDATA_o,
  output logic                PREADY_o,
  output logic                PSLVERR_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFFS_W = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_W - OFFS_W;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'((1 << OFFS_W) - 1);

  apb_slv_state_t state_q, state_d;
  logic           pready_q, pready_d;

  // Transfer fields frozen at the setup edge.
  logic              write_q;
  logic              err_q;
  logic [MEM_AW-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic                  capture, commit, cnt_load, cnt_dec, cnt_zero;
  logic [WAIT_CNT_W-1:0] cnt_count;
  logic [IDX_W-1:0]      req_idx;
  logic                  req_err;

  assign req_idx = IDX_W'(PADDR_i >> OFFS_W);
  assign req_err = (32'(req_idx) >= DEPTH) || ((PADDR_i & OFFS_MASK) != '0) ||
                   (PWRITE_i && (32'(req_idx) >= RO_BASE));

  apb_wait_counter u_wait_counter (
    .PCLK      (PCLK),
    .PRESET_n  (PRESET_n),
    .load_i    (cnt_load),
    .load_val_i(WAIT_CNT_W'(WAIT_CYCLES)),
    .dec_i     (cnt_dec),
    .count_o   (cnt_count),
    .zero_o    (cnt_zero)
  );

  // Next-state: PREADY is precomputed one cycle ahead so the output stays a flop.
  always_comb begin
    state_d  = state_q;
    pready_d = 1'b0;
    capture  = 1'b0;
    commit   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE, COMPLETE: begin
        if (PSEL_i && !PENABLE_i) begin
          capture  = 1'b1;
          cnt_load = 1'b1;
          state_d  = ACCESS;
          pready_d = (WAIT_CYCLES == 0);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!PSEL_i) begin
          state_d = IDLE;
        end else if (pready_q && PENABLE_i) begin
          commit  = 1'b1;
          state_d = COMPLETE;
        end else begin
          cnt_dec  = 1'b1;
          pready_d = cnt_zero || (cnt_count == WAIT_CNT_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and ready registers.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_q  <= IDLE;
      pready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pready_q <= pready_d;
    end
  end

  // Capture transfer fields at setup; later bus activity is ignored.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (capture) begin
      write_q <= PWRITE_i;
      err_q   <= req_err;
      idx_q   <= req_idx[MEM_AW-1:0];
      wdata_q <= PWDATA_i;
      strb_q  <= PSTRB_i;
    end
  end

  // Memory array: cleared on reset, byte-lane writes at the completion edge.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit && write_q && !err_q) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign PREADY_o  = pready_q;
  assign PSLVERR_o = pready_q ? (err_q ? APB_RESP_ERR : APB_RESP_OKAY) : APB_RESP_OKAY;
  assign PRDATA_o  = (pready_q && !write_q && !err_q) ? mem_q[idx_q] : '0;

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock PCLK, reset PRESET_n.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width in bits; legal values are 8, 16 and 32.
REQ-003 Parameter ADDR_W, default 12, SHALL set the byte-address width.
REQ-004 Parameter DEPTH, default 256, SHALL set the number of words; it must be at most 2^(ADDR_W - log2(DATA_W/8)).
REQ-005 Parameter WAIT_CYCLES, default 2, range 0..15, SHALL set the number of wait states inserted per transfer.
REQ-006 Parameter RO_BASE, default DEPTH, SHALL set the first read-only word index; RO_BASE = DEPTH means no read-only region.
REQ-007 Ports, listed as name, direction, width, meaning:
- PCLK, in, 1, clock.
- PRESET_n, in, 1, asynchronous active-low reset.
- PSEL_i, in, 1, slave select.
- PENABLE_i, in, 1, access-phase flag.
- PWRITE_i, in, 1, 1 = write, 0 = read.
- PADDR_i, in, ADDR_W, byte address.
- PWDATA_i, in, DATA_W, write data.
- PSTRB_i, in, DATA_W/8, byte-lane write strobes.
- PRDATA_o, out, DATA_W, read data.
- PREADY_o, out, 1, transfer complete.
- PSLVERR_o, out, 1, transfer error.

Function
REQ-008 Word index SHALL be PADDR_i[ADDR_W-1 : log2(DATA_W/8)].
REQ-009 The FSM SHALL have three states: IDLE, ACCESS and COMPLETE.
REQ-010 In IDLE, PSEL_i=1 with PENABLE_i=0 SHALL be the setup phase; at that edge the FSM SHALL capture address, direction, write data and strobes, load the wait counter with WAIT_CYCLES, and enter ACCESS.
REQ-011 Fields captured at setup SHALL be used for the whole transfer; bus changes during the access phase are ignored.
REQ-012 In ACCESS, PREADY_o SHALL go high in access cycle WAIT_CYCLES+1, counting the first PENABLE_i=1 cycle as 1; this is a registered output, with no combinational path from inputs to PREADY_o.
REQ-013 The transfer SHALL complete at the edge where PSEL_i, PENABLE_i and PREADY_o are all 1; on completion the FSM enters COMPLETE for one cycle with PREADY_o low.
REQ-014 From COMPLETE, the FSM SHALL accept a new setup (back-to-back transfer) or return to IDLE.
REQ-015 The error condition SHALL be any of: word index >= DEPTH; nonzero byte-offset bits; a write with word index >= RO_BASE.
REQ-016 PSLVERR_o SHALL equal the error condition during the PREADY_o cycle and SHALL be 0 at all other times.
REQ-017 A write without error SHALL update only the byte lanes whose PSTRB_i bit is 1, committed at the completion edge.
REQ-018 A write with PSTRB_i=0 SHALL complete normally and leave memory unchanged.
REQ-019 A write with error SHALL leave memory unchanged.
REQ-020 A read SHALL drive the addressed word on PRDATA_o during the PREADY_o cycle.
REQ-021 PRDATA_o SHALL be 0 for reads with error, for writes, and whenever PREADY_o is 0.
REQ-022 PSTRB_i SHALL be ignored for reads.
REQ-023 If PSEL_i drops in ACCESS before completion, the FSM SHALL abort to IDLE: no memory update, PREADY_o 0, PSLVERR_o 0.
REQ-024 PENABLE_i=1 in IDLE without a preceding setup SHALL be ignored, with PREADY_o held at 0.
REQ-025 The wait counter SHALL saturate at 0 and never wrap.

Reset
REQ-026 When PRESET_n=0, asynchronously: the FSM SHALL go to IDLE, PREADY_o, PSLVERR_o and PRDATA_o SHALL be 0, and all memory words SHALL be cleared to 0.
REQ-027 Reset asserted mid-transfer SHALL discard the transfer with no memory update; after deassertion, the first valid setup SHALL be honoured.

Structure
REQ-028 Package apb_pkg SHALL hold the FSM state enum apb_slv_state_t (IDLE, ACCESS, COMPLETE) and the constants APB_RESP_OKAY=0 and APB_RESP_ERR=1.
REQ-029 The wait-state countdown SHALL be a sub-module apb_wait_counter (load, decrement, zero flag); memory, decode and FSM stay in apb_mem_slave.

Verification
REQ-030 With DATA_W=32 and WAIT_CYCLES=2: write 0xDEADBEEF to 0x010 with PSTRB=0xF, then read 0x010 -> PREADY_o high in access cycle 3, PRDATA_o=0xDEADBEEF, PSLVERR_o=0.
REQ-031 Strobe write: write 0x11223344 to 0x020 with PSTRB=0xF, then 0xAABBCCDD with PSTRB=0x5, then read -> 0x11BB33DD.
REQ-032 Errors: read 0x400 (word 256, DEPTH=256) -> PSLVERR_o=1, PRDATA_o=0; write to 0x013 (misaligned) -> PSLVERR_o=1 and word 4 unchanged.
REQ-033 With RO_BASE=192: write 0x55 to 0x300 -> PSLVERR_o=1; a read of the same address returns the prior value 0 with PSLVERR_o=0.
REQ-034 With WAIT_CYCLES=0: back-to-back write then read to 0x004 -> PREADY_o high in the first access cycle of each transfer; the read returns the written data.
REQ-035 Abort and reset: drop PSEL_i in access cycle 2 of a write -> no update; assert PRESET_n=0 mid-transfer -> outputs 0 immediately and memory reads back 0 afterwards.
